// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned level/pulse outputs
// The slave side is the conditioner; the master side drives the switches and consumes the pulses.
interface button_conditioner_if #(
   parameter int N_BTN = 8
);
   logic [N_BTN-1:0] btn_n;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;

   modport master (
      output btn_n,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_repeat
   );

   modport slave (
      input  btn_n,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_repeat
   );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer and press/release/repeat pulse generator
// Every bit is independent; all outputs are registered and line up with the debounced level edge.
module button_conditioner #(
   parameter int N_BTN           = 8,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_RATE     = 1
) (
   input  logic clk,
   input  logic rst,
   button_conditioner_if.slave bus
);
   localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW     = $clog2(RMAX + 1);
   localparam bit REP_EN = (REPEAT_DELAY != 0);

   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] s;
   logic [N_BTN-1:0] level_q;
   logic [N_BTN-1:0] press_q;
   logic [N_BTN-1:0] rel_q;
   logic [N_BTN-1:0] rpt_q;
   logic [N_BTN-1:0] rep_first;
   logic [N_BTN-1:0] toggle;
   logic [CW-1:0]    db_cnt  [N_BTN];
   logic [RW-1:0]    rep_cnt [N_BTN];

   assign s = ~sync2;

   always_comb begin
      toggle = '0;
      for (int i = 0; i < N_BTN; i++) begin
         toggle[i] = (s[i] != level_q[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '1;
         sync2     <= '1;
         level_q   <= '0;
         press_q   <= '0;
         rel_q     <= '0;
         rpt_q     <= '0;
         rep_first <= '1;
         for (int i = 0; i < N_BTN; i++) begin
            db_cnt[i]  <= '0;
            rep_cnt[i] <= '0;
         end
      end else begin
         sync1 <= bus.btn_n;
         sync2 <= sync1;
         for (int i = 0; i < N_BTN; i++) begin
            press_q[i] <= 1'b0;
            rel_q[i]   <= 1'b0;
            rpt_q[i]   <= 1'b0;

            if (s[i] == level_q[i]) begin
               db_cnt[i] <= '0;
            end else if (toggle[i]) begin
               level_q[i] <= s[i];
               db_cnt[i]  <= '0;
               press_q[i] <= s[i];
               rel_q[i]   <= ~s[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end

            // The press cycle itself clears the repeat count, so no repeat can coincide with a press.
            if (!REP_EN || !level_q[i] || toggle[i]) begin
               rep_cnt[i]   <= '0;
               rep_first[i] <= 1'b1;
            end else if (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : RATE_LAST)) begin
               rep_cnt[i]   <= '0;
               rep_first[i] <= 1'b0;
               rpt_q[i]     <= 1'b1;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = rel_q;
   assign bus.btn_repeat  = rpt_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed checks of debounce latency, bounce rejection, repeat and reset
module tb_button_conditioner;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   button_conditioner_if #(.N_BTN(8)) bus ();

   button_conditioner #(
      .N_BTN(8),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_RATE(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " lvl"}, bus.btn_level, 8'h00);
      check({tag, " prs"}, bus.btn_press, 8'h00);
      check({tag, " rel"}, bus.btn_release, 8'h00);
      check({tag, " rpt"}, bus.btn_repeat, 8'h00);
   endtask

   // Edge e is the e-th posedge of the scenario; the buttons in mask are held on edges 1..hold_end
   // except where bounce_hi marks a high sample. p_edge/r_edge are the hand-derived press/release edges
   // (p_edge = 0 means no press is expected); repeats follow at p_edge+10, +13, +16 ... before r_edge.
   task automatic run_scn(input string name, input logic [7:0] mask, input int hold_end,
                          input logic [63:0] bounce_hi, input int p_edge, input int r_edge, input int n);
      logic       pressed;
      logic [7:0] e_lvl, e_prs, e_rel, e_rpt;
      for (int e = 1; e <= n; e++) begin
         pressed   = (e <= hold_end) && !bounce_hi[e];
         bus.btn_n = pressed ? ~mask : 8'hFF;
         @(posedge clk);
         @(negedge clk);
         e_lvl = (p_edge != 0 && e >= p_edge && e < r_edge) ? mask : 8'h00;
         e_prs = (p_edge != 0 && e == p_edge) ? mask : 8'h00;
         e_rel = (p_edge != 0 && e == r_edge) ? mask : 8'h00;
         e_rpt = (p_edge != 0 && e >= p_edge + 10 && e < r_edge && ((e - p_edge - 10) % 3 == 0)) ? mask : 8'h00;
         check($sformatf("%s e%0d lvl", name, e), bus.btn_level, e_lvl);
         check($sformatf("%s e%0d prs", name, e), bus.btn_press, e_prs);
         check($sformatf("%s e%0d rel", name, e), bus.btn_release, e_rel);
         check($sformatf("%s e%0d rpt", name, e), bus.btn_repeat, e_rpt);
      end
   endtask

   task automatic do_reset(input int cycles, input logic [7:0] held);
      bus.btn_n = held;
      rst       = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         @(negedge clk);
         check_idle($sformatf("reset c%0d", k));
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.btn_n = 8'hFF;
      rst       = 1'b1;
      @(negedge clk);
      do_reset(3, 8'hFF);

      run_scn("idle", 8'h01, 0, 64'h0, 0, 0, 10);
      run_scn("clean", 8'h01, 20, 64'h0, 6, 26, 30);
      run_scn("bounce", 8'h02, 15, 64'h90, 13, 21, 24);
      run_scn("repeat", 8'h04, 30, 64'h0, 6, 36, 40);
      run_scn("simul", 8'h09, 8, 64'h0, 6, 14, 18);

      // Three low samples, then reset aborts the count; the still-held button re-presses afterwards.
      run_scn("midcount", 8'h01, 3, 64'h0, 0, 0, 3);
      do_reset(3, 8'hFE);
      run_scn("held", 8'h01, 8, 64'h0, 6, 14, 18);

      do_reset(2, 8'hFF);
      run_scn("glitch", 8'h01, 2, 64'h0, 0, 0, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
